// File: rtl/posit_pkg.sv
// Shared posit geometry, special encodings and helpers
// for the posit packing back end.
package posit_pkg;

  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int N  = 8;
  localparam int ES = 2;
  localparam int FW = 8;
  localparam int BS = log2(N);
  localparam int SW = BS + ES + 2;
  localparam int BW = 2 * N + FW;

  localparam logic [N-1:0] NAR    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ZERO   = '0;
  localparam logic [N-1:0] MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MINPOS = N'(1);

endpackage

// File: rtl/posit_regime_build.sv
// Stage-1 combinational logic: scale to saturation flags
// and a left-aligned {regime, exponent, fraction} body.
module posit_regime_build
  import posit_pkg::*;
(
  input  logic signed [SW-1:0] scale,
  input  logic [FW-1:0]        frac,
  output logic                 sat_max,
  output logic                 sat_min,
  output logic [BW-1:0]        body
);

  localparam int PAD = BW - 1 - ES - FW;
  localparam logic signed [SW-1:0] SAT = SW'((N - 2) << ES);

  logic signed [SW-1:0] k;
  logic [SW-1:0]        amt;
  logic [BW-1:0]        tail;

  always_comb begin
    k       = scale >>> ES;
    sat_max = scale > SAT;
    sat_min = scale < -SAT;
    tail    = {1'b1, scale[ES-1:0], frac, {PAD{1'b0}}};
    // negative k: -k zeros then the terminating one (tail MSB)
    if (k[SW-1]) begin
      amt  = -k;
      body = tail >> amt;
    end else begin
      amt  = k + SW'(1);
      body = ~({BW{1'b1}} >> amt)
           | ({1'b0, tail[BW-2:0]} >> amt);
    end
  end

endmodule

// File: rtl/posit_encoder.sv
// Two-stage valid/ready posit packer: regime build,
// then round-to-nearest-even with saturation and sign.
module posit_encoder
  import posit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic                 in_zero,
  input  logic                 in_nar,
  input  logic signed [SW-1:0] in_scale,
  input  logic [FW-1:0]        in_frac,
  input  logic                 in_sticky,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_posit
);

  logic          s1_valid, s2_valid;
  logic          s1_sign, s1_zero, s1_nar;
  logic          s1_max, s1_min, s1_sticky;
  logic [BW-1:0] s1_body;

  logic          sat_max, sat_min;
  logic [BW-1:0] body;
  logic          adv1, adv2;

  logic [N-2:0]  mag, mag_r;
  logic          guard, stk;
  logic [N-1:0]  sum, word;

  assign adv2      = out_ready | ~s2_valid;
  assign adv1      = adv2 | ~s1_valid;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  posit_regime_build u_regime (
    .scale   (in_scale),
    .frac    (in_frac),
    .sat_max (sat_max),
    .sat_min (sat_min),
    .body    (body)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_posit <= ZERO;
    end else begin
      if (adv1) s1_valid <= in_valid;
      if (adv2) s2_valid <= s1_valid;
      if (adv2 && s1_valid) out_posit <= word;
    end
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_sign   <= in_sign;
      s1_zero   <= in_zero;
      s1_nar    <= in_nar;
      s1_max    <= sat_max;
      s1_min    <= sat_min;
      s1_sticky <= in_sticky;
      s1_body   <= body;
    end
  end

  always_comb begin
    mag   = s1_body[BW-1 -: N-1];
    guard = s1_body[BW-N];
    stk   = (|s1_body[BW-N-1:0]) | s1_sticky;
    sum   = {1'b0, mag} + N'(guard & (stk | mag[0]));
    mag_r = sum[N-1] ? MAXPOS[N-2:0] : sum[N-2:0];
    // a nonzero value never packs to zero
    if (mag_r == '0) mag_r = MINPOS[N-2:0];
    if (s1_max) mag_r = MAXPOS[N-2:0];
    if (s1_min) mag_r = MINPOS[N-2:0];
    word = s1_sign ? -{1'b0, mag_r} : {1'b0, mag_r};
    if (s1_zero) word = ZERO;
    if (s1_nar) word = NAR;
  end

endmodule

// File: tb/tb_posit_encoder.sv
// Bench for posit_encoder: bit-string reference model,
// scoreboard monitor and directed vectors.
module tb_posit_encoder;
  import posit_pkg::*;

  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0, in_sign = 0, in_zero = 0;
  logic in_nar = 0, in_sticky = 0, out_ready = 1;
  logic signed [SW-1:0] in_scale = '0;
  logic [FW-1:0] in_frac = '0;
  logic in_ready, out_valid;
  logic [N-1:0] out_posit;

  int checks = 0, errors = 0, cyc = 0;
  bit lat_chk = 0, held_v = 0;
  logic [N-1:0] held_p;
  logic [N-1:0] expq[$];
  int accq[$];
  int bp_idx;
  int bp_sc[4] = '{0, 4, -1, 8};

  posit_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_zero   (in_zero),
    .in_nar    (in_nar),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: write out the posit bit string, then round it.
  function automatic logic [N-1:0] model(bit s, bit z, bit n,
                                         int sc, int fr, bit st);
    bit q[$];
    int k, e, mag, sat, step;
    bit g, sk;
    if (n) return NAR;
    if (z) return ZERO;
    step = 1 << ES;
    sat = (N - 2) * step;
    if (sc > sat) mag = (1 << (N - 1)) - 1;
    else if (sc < -sat) mag = 1;
    else begin
      k = (sc >= 0) ? sc / step : -((-sc + step - 1) / step);
      e = sc - k * step;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        for (int i = 0; i < -k; i++) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = ES - 1; i >= 0; i--) q.push_back(bit'((e >> i) & 1));
      for (int i = FW - 1; i >= 0; i--) q.push_back(bit'((fr >> i) & 1));
      mag = 0;
      for (int i = 0; i < N - 1; i++) mag = mag * 2 + int'(q[i]);
      g = q[N-1];
      sk = st;
      for (int i = N; i < q.size(); i++) sk = sk | q[i];
      if (g && (sk || (mag % 2 == 1))) mag++;
      if (mag > (1 << (N - 1)) - 1) mag = (1 << (N - 1)) - 1;
      if (mag == 0) mag = 1;
    end
    return s ? N'((1 << N) - mag) : N'(mag);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) begin
        expq.push_back(model(in_sign, in_zero, in_nar, int'(in_scale),
                             int'(in_frac), in_sticky));
        accq.push_back(cyc);
      end
      if (held_v) begin
        check("hold_valid", int'(out_valid), 1);
        check("hold_posit", int'(out_posit), int'(held_p));
      end
      held_v = out_valid && !out_ready;
      held_p = out_posit;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check("extra_output", int'(out_posit), -1);
        else begin
          logic [N-1:0] ev;
          int a;
          ev = expq.pop_front();
          a = accq.pop_front();
          check("out", int'(out_posit), int'(ev));
          if (lat_chk) check("latency", cyc - a, 2);
        end
      end
    end
  end

  task automatic send(string nm, bit s, bit z, bit n,
                      int sc, int fr, bit st, int exp);
    int t;
    t = 0;
    in_sign = s; in_zero = z; in_nar = n;
    in_scale = SW'(sc); in_frac = FW'(fr); in_sticky = st;
    in_valid = 1;
    if (exp >= 0) check(nm, int'(model(s, z, n, sc, fr, st)), exp);
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid = 0;
    while (expq.size() != 0 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", expq.size(), 0);
  endtask

  initial begin
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_posit", int'(out_posit), 0);
    #2 rst = 0;
    @(posedge clk); #1;

    lat_chk = 1;
    send("basic0", 0, 0, 0, 0, 'h00, 0, 'h40);
    send("basic_neg", 1, 0, 0, 0, 'h00, 0, 'hC0);
    send("basic_s4", 0, 0, 0, 4, 'h00, 0, 'h60);
    send("basic_sm1", 0, 0, 0, -1, 'h00, 0, 'h38);
    send("basic_s1", 0, 0, 0, 1, 'h80, 0, 'h4C);
    send("neg_sm1", 1, 0, 0, -1, 'h00, 0, 'hC8);
    send("rnd_tie_even", 0, 0, 0, 0, 'h10, 0, 'h40);
    send("rnd_sticky", 0, 0, 0, 0, 'h10, 1, 'h41);
    send("rnd_tie_odd", 0, 0, 0, 0, 'h30, 0, 'h42);
    send("rnd_carry", 0, 0, 0, 0, 'hF0, 0, 'h48);
    send("sat_max", 0, 0, 0, 30, 'h00, 0, 'h7F);
    send("sat_min", 0, 0, 0, -30, 'h00, 0, 'h01);
    send("minpos_edge", 0, 0, 0, -24, 'h00, 0, 'h01);
    send("maxpos_edge", 0, 0, 0, 24, 'hFF, 0, 'h7F);
    send("neg_max", 1, 0, 0, 30, 'h00, 0, 'h81);
    send("zero", 1, 1, 0, 7, 'h55, 1, 'h00);
    send("nar", 1, 1, 1, -5, 'h12, 0, 'h80);
    drain();
    lat_chk = 0;

    out_ready = 0;
    bp_idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_sign = 0; in_zero = 0; in_nar = 0; in_sticky = 0;
      in_frac = '0; in_scale = SW'(bp_sc[bp_idx]); in_valid = 1;
      @(negedge clk);
      if (in_ready) bp_idx++;
      @(posedge clk); #1;
    end
    check("bp_accepted", bp_idx, 2);
    check("bp_in_ready", int'(in_ready), 0);
    check("bp_out_valid", int'(out_valid), 1);
    check("bp_hold_first", int'(out_posit), 'h40);
    out_ready = 1;
    send("bp_item2", 0, 0, 0, bp_sc[2], 'h00, 0, 'h38);
    send("bp_item3", 0, 0, 0, bp_sc[3], 'h00, 0, 'h70);
    drain();

    out_ready = 0;
    send("rs_a", 0, 0, 0, 0, 'h00, 0, 'h40);
    send("rs_b", 0, 0, 0, 4, 'h00, 0, 'h60);
    in_valid = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("rs_out_valid", int'(out_valid), 0);
    check("rs_in_ready", int'(in_ready), 1);
    check("rs_out_posit", int'(out_posit), 0);
    expq.delete();
    accq.delete();
    held_v = 0;
    out_ready = 1;
    @(posedge clk);
    #3 rst = 0;
    @(posedge clk); #1;
    lat_chk = 1;
    send("rs_new1", 0, 0, 0, 1, 'h80, 0, 'h4C);
    send("rs_new2", 1, 0, 0, -30, 'h00, 0, 'hFF);
    drain();
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
